inst_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
//  It accepts the fetch address and returns a 32-bit instruction plus a ready strobe.

---
 rtl/inst_cache_if.sv | 24 ++
 rtl/inst_cache.sv | 116 +++++++++++
 tb/tb_inst_cache.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
// The cache takes the slave view and the fetch/arbiter side takes the master view.
interface inst_cache_if;
   logic        rdy_in;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        abort_in;
   logic        ready_out;
   logic [31:0] inst_out;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [7:0]  mem_byte;
   logic        mem_byte_valid;

   modport slave (
      input  rdy_in, fetch_req, fetch_addr, abort_in, mem_byte, mem_byte_valid,
      output ready_out, inst_out, mem_req, mem_addr
   );

   modport master (
      output rdy_in, fetch_req, fetch_addr, abort_in, mem_byte, mem_byte_valid,
      input  ready_out, inst_out, mem_req, mem_addr
   );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache holding one 32-bit word per line.
// A miss refills the line from byte-wide memory, one byte per beat, little-endian.
module inst_cache #(
   parameter int IDX_W = 8,
   parameter int TAG_W = 32 - IDX_W - 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   inst_cache_if.slave bus
);
   localparam int NUM_LINES = 2 ** IDX_W;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [23:0]          line_buf_q, line_buf_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;

   logic [TAG_W-1:0]     tag_arr [NUM_LINES];
   logic [31:0]          data_arr [NUM_LINES];

   logic [IDX_W-1:0]     req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic [IDX_W-1:0]     line_idx;
   logic [TAG_W-1:0]     line_tag;
   logic                 hit;
   logic                 wr_en;
   logic [31:0]          wr_word;
   logic                 unused_addr_bits;

   assign req_idx          = bus.fetch_addr[IDX_W+1:2];
   assign req_tag          = bus.fetch_addr[31:IDX_W+2];
   assign unused_addr_bits = ^bus.fetch_addr[1:0];

   // The refill address register doubles as the latched line base: it only
   // advances through the byte offset, so its index/tag bits stay on the line.
   assign line_idx = mem_addr_q[IDX_W+1:2];
   assign line_tag = mem_addr_q[31:IDX_W+2];

   assign hit = bus.fetch_req & valid_q[req_idx] & (tag_arr[req_idx] == req_tag)
              & (state_q == IDLE) & bus.rdy_in;

   assign bus.ready_out = hit;
   assign bus.inst_out  = hit ? data_arr[req_idx] : 32'd0;
   assign bus.mem_req   = (state_q == REFILL);
   assign bus.mem_addr  = mem_addr_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_addr_d = mem_addr_q;
      line_buf_d = line_buf_q;
      valid_d    = valid_q;
      wr_en      = 1'b0;
      wr_word    = {bus.mem_byte, line_buf_q};

      if (bus.rdy_in) begin
         case (state_q)
            IDLE: begin
               if (bus.fetch_req && !hit && !bus.abort_in) begin
                  state_d    = REFILL;
                  cnt_d      = 2'd0;
                  mem_addr_d = {bus.fetch_addr[31:2], 2'b00};
               end
            end
            REFILL: begin
               // Abort takes priority over an arriving beat, including the last one.
               if (bus.abort_in) begin
                  state_d = IDLE;
                  cnt_d   = 2'd0;
               end else if (bus.mem_byte_valid) begin
                  cnt_d      = cnt_q + 2'd1;
                  mem_addr_d = mem_addr_q + 32'd1;
                  case (cnt_q)
                     2'd0: line_buf_d[7:0]   = bus.mem_byte;
                     2'd1: line_buf_d[15:8]  = bus.mem_byte;
                     2'd2: line_buf_d[23:16] = bus.mem_byte;
                     default: begin
                        wr_en             = 1'b1;
                        valid_d[line_idx] = 1'b1;
                        state_d           = IDLE;
                     end
                  endcase
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         mem_addr_q <= 32'd0;
         line_buf_q <= 24'd0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         line_buf_q <= line_buf_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and data storage is left unreset; the valid bits alone gate hits.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         tag_arr[line_idx]  <= line_tag;
         data_arr[line_idx] <= wr_word;
      end
   end
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hit, conflict, abort, stall and
// asynchronous reset scenarios with hand-computed expected values.
module tb_inst_cache;
   logic clk_in = 1'b0;
   logic rst_in;
   int   checks_total  = 0;
   int   checks_passed = 0;

   inst_cache_if bus();

   inst_cache #(.IDX_W(8)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_in);
   endtask

   // Feeds beats first..last of a refill, counting beats whose mem_req/mem_addr were wrong.
   task automatic serve(input logic [31:0] base, input logic [31:0] word,
                        input int first, input int last, output int bad);
      bad = 0;
      for (int i = first; i <= last; i++) begin
         bus.mem_byte       = word[8*i +: 8];
         bus.mem_byte_valid = 1'b1;
         sample();
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== base + 32'(i)) bad++;
         step();
      end
      bus.mem_byte_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_in             = 1'b1;
      bus.rdy_in         = 1'b1;
      bus.fetch_req      = 1'b0;
      bus.fetch_addr     = 32'd0;
      bus.abort_in       = 1'b0;
      bus.mem_byte       = 8'd0;
      bus.mem_byte_valid = 1'b0;
      #12;
      checks_total++;
      if (bus.mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req got %0b expected 0", bus.mem_req);
      else checks_passed++;
      checks_total++;
      if (bus.mem_addr !== 32'd0) $display("[TB] FAIL reset_mem_addr got %h expected 0", bus.mem_addr);
      else checks_passed++;
      checks_total++;
      if (bus.ready_out !== 1'b0 || bus.inst_out !== 32'd0)
         $display("[TB] FAIL reset_outputs got ready=%0b inst=%h expected 0/0", bus.ready_out, bus.inst_out);
      else checks_passed++;
      step();
      rst_in = 1'b0;
   endtask

   task automatic test_cold_miss();
      logic [7:0] beats [4];
      beats = '{8'h13, 8'h05, 8'h10, 8'h00};
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0000;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0 || bus.mem_req !== 1'b0)
         $display("[TB] FAIL t1_miss_cycle0 got ready=%0b req=%0b expected 0/0", bus.ready_out, bus.mem_req);
      else checks_passed++;
      step();
      for (int i = 0; i < 4; i++) begin
         bus.mem_byte       = beats[i];
         bus.mem_byte_valid = 1'b1;
         sample();
         checks_total++;
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'(i) || bus.ready_out !== 1'b0)
            $display("[TB] FAIL t1_beat%0d got req=%0b addr=%h ready=%0b expected 1/%h/0",
                     i, bus.mem_req, bus.mem_addr, bus.ready_out, i);
         else checks_passed++;
         step();
      end
      bus.mem_byte_valid = 1'b0;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b1 || bus.inst_out !== 32'h0010_0513)
         $display("[TB] FAIL t1_fill_result got ready=%0b inst=%h expected 1/00100513", bus.ready_out, bus.inst_out);
      else checks_passed++;
      checks_total++;
      if (bus.mem_req !== 1'b0) $display("[TB] FAIL t1_req_drop got %0b expected 0", bus.mem_req);
      else checks_passed++;
   endtask

   task automatic test_hit();
      step();
      bus.fetch_addr = 32'h0000_0003;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b1 || bus.inst_out !== 32'h0010_0513 || bus.mem_req !== 1'b0)
         $display("[TB] FAIL t2_hit got ready=%0b inst=%h req=%0b expected 1/00100513/0",
                  bus.ready_out, bus.inst_out, bus.mem_req);
      else checks_passed++;
      step();
      sample();
      checks_total++;
      if (bus.mem_req !== 1'b0) $display("[TB] FAIL t2_no_refill got %0b expected 0", bus.mem_req);
      else checks_passed++;
      step();
      bus.fetch_req = 1'b0;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0 || bus.inst_out !== 32'd0)
         $display("[TB] FAIL t2_idle_outputs got ready=%0b inst=%h expected 0/0", bus.ready_out, bus.inst_out);
      else checks_passed++;
      step();
   endtask

   task automatic test_conflict();
      int bad;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0400;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0) $display("[TB] FAIL t3_conflict_miss got %0b expected 0", bus.ready_out);
      else checks_passed++;
      step();
      serve(32'h400, 32'hDEAD_BEEF, 0, 3, bad);
      checks_total++;
      if (bad !== 0) $display("[TB] FAIL t3_refill_400 bad_beats=%0d expected 0", bad);
      else checks_passed++;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b1 || bus.inst_out !== 32'hDEAD_BEEF)
         $display("[TB] FAIL t3_hit_400 got ready=%0b inst=%h expected 1/deadbeef", bus.ready_out, bus.inst_out);
      else checks_passed++;
      step();
      bus.fetch_addr = 32'h0000_0000;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0) $display("[TB] FAIL t3_evicted_miss got %0b expected 0", bus.ready_out);
      else checks_passed++;
      step();
      sample();
      checks_total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd0)
         $display("[TB] FAIL t3_refill_000 got req=%0b addr=%h expected 1/0", bus.mem_req, bus.mem_addr);
      else checks_passed++;
      step();
      serve(32'h0, 32'h0010_0513, 0, 3, bad);
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b1 || bus.inst_out !== 32'h0010_0513 || bad !== 0)
         $display("[TB] FAIL t3_rehit_000 got ready=%0b inst=%h bad=%0d expected 1/00100513/0",
                  bus.ready_out, bus.inst_out, bad);
      else checks_passed++;
      step();
   endtask

   task automatic test_abort();
      int bad;
      bus.fetch_addr = 32'h0000_0010;
      step();
      serve(32'h10, 32'h4433_2211, 0, 1, bad);
      bus.abort_in       = 1'b1;
      bus.mem_byte       = 8'h33;
      bus.mem_byte_valid = 1'b1;
      sample();
      checks_total++;
      if (bus.mem_addr !== 32'h12 || bad !== 0)
         $display("[TB] FAIL t4_pre_abort got addr=%h bad=%0d expected 12/0", bus.mem_addr, bad);
      else checks_passed++;
      step();
      bus.abort_in       = 1'b0;
      bus.mem_byte_valid = 1'b0;
      bus.fetch_req      = 1'b0;
      sample();
      checks_total++;
      if (bus.mem_req !== 1'b0) $display("[TB] FAIL t4_abort_idle got req=%0b expected 0", bus.mem_req);
      else checks_passed++;
      step();
      bus.abort_in  = 1'b1;
      bus.fetch_req = 1'b1;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0) $display("[TB] FAIL t4_not_written got %0b expected 0", bus.ready_out);
      else checks_passed++;
      step();
      sample();
      checks_total++;
      if (bus.mem_req !== 1'b0) $display("[TB] FAIL t4_abort_blocks_miss got %0b expected 0", bus.mem_req);
      else checks_passed++;
      step();
      bus.abort_in = 1'b0;
      step();
      serve(32'h10, 32'h4433_2211, 0, 3, bad);
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b1 || bus.inst_out !== 32'h4433_2211 || bad !== 0)
         $display("[TB] FAIL t4_refetch got ready=%0b inst=%h bad=%0d expected 1/44332211/0",
                  bus.ready_out, bus.inst_out, bad);
      else checks_passed++;
      step();
      // Abort coinciding with the last beat must leave the line unwritten.
      bus.fetch_addr = 32'h0000_0020;
      step();
      serve(32'h20, 32'h8765_4321, 0, 2, bad);
      bus.abort_in       = 1'b1;
      bus.mem_byte       = 8'h87;
      bus.mem_byte_valid = 1'b1;
      step();
      bus.abort_in       = 1'b0;
      bus.mem_byte_valid = 1'b0;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0 || bus.mem_req !== 1'b0 || bad !== 0)
         $display("[TB] FAIL t4_abort_last_beat got ready=%0b req=%0b bad=%0d expected 0/0/0",
                  bus.ready_out, bus.mem_req, bad);
      else checks_passed++;
      step();
      bus.abort_in  = 1'b1;
      bus.fetch_req = 1'b0;
      step();
      bus.abort_in = 1'b0;
   endtask

   task automatic test_stall();
      int bad;
      int bad2;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0030;
      step();
      serve(32'h30, 32'hDDCC_BBAA, 0, 1, bad);
      bus.rdy_in         = 1'b0;
      bus.mem_byte       = 8'hFF;
      bus.mem_byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks_total++;
         if (bus.mem_addr !== 32'h32 || bus.mem_req !== 1'b1 || bus.ready_out !== 1'b0)
            $display("[TB] FAIL t5_stall%0d got addr=%h req=%0b ready=%0b expected 32/1/0",
                     i, bus.mem_addr, bus.mem_req, bus.ready_out);
         else checks_passed++;
         step();
      end
      bus.rdy_in = 1'b1;
      serve(32'h30, 32'hDDCC_BBAA, 2, 3, bad2);
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b1 || bus.inst_out !== 32'hDDCC_BBAA || bad !== 0 || bad2 !== 0)
         $display("[TB] FAIL t5_resume got ready=%0b inst=%h bad=%0d/%0d expected 1/ddccbbaa/0/0",
                  bus.ready_out, bus.inst_out, bad, bad2);
      else checks_passed++;
      step();
      bus.rdy_in = 1'b0;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0 || bus.inst_out !== 32'd0)
         $display("[TB] FAIL t5_rdy_low_hit got ready=%0b inst=%h expected 0/0", bus.ready_out, bus.inst_out);
      else checks_passed++;
      step();
      bus.rdy_in    = 1'b1;
      bus.fetch_req = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      int bad;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0040;
      step();
      serve(32'h40, 32'h1122_3344, 0, 2, bad);
      bus.mem_byte       = 8'h11;
      bus.mem_byte_valid = 1'b1;
      #2;
      rst_in = 1'b1;
      #1;
      checks_total++;
      if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'd0 || bus.ready_out !== 1'b0 || bus.inst_out !== 32'd0)
         $display("[TB] FAIL t6_async_reset got req=%0b addr=%h ready=%0b inst=%h expected 0/0/0/0",
                  bus.mem_req, bus.mem_addr, bus.ready_out, bus.inst_out);
      else checks_passed++;
      step();
      rst_in             = 1'b0;
      bus.mem_byte_valid = 1'b0;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0 || bad !== 0)
         $display("[TB] FAIL t6_rerequest_miss got ready=%0b bad=%0d expected 0/0", bus.ready_out, bad);
      else checks_passed++;
      step();
      sample();
      checks_total++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40)
         $display("[TB] FAIL t6_refill_restart got req=%0b addr=%h expected 1/40", bus.mem_req, bus.mem_addr);
      else checks_passed++;
      step();
      bus.abort_in  = 1'b1;
      bus.fetch_req = 1'b0;
      step();
      bus.abort_in   = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0000;
      sample();
      checks_total++;
      if (bus.ready_out !== 1'b0)
         $display("[TB] FAIL t6_valid_cleared got ready=%0b expected 0", bus.ready_out);
      else checks_passed++;
      step();
      bus.abort_in  = 1'b1;
      bus.fetch_req = 1'b0;
      step();
      bus.abort_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_abort();
      test_stall();
      test_async_reset();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
